// File: rtl/dma_multi_ch.sv
// Multi-channel DMA engine: round-robin arbitration between channels, one word per read/write pair,
// up to BURST_LEN words per bus tenure. Define DMA_MULTI_CH_IRQ_EN to add sticky completion status and irq.
module dma_multi_ch #(
  parameter int NUM_CH    = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 16,
  parameter int BURST_LEN = 8,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_start,
  input  logic [NUM_CH*ADDR_W-1:0] ch_src_addr,
  input  logic [NUM_CH*ADDR_W-1:0] ch_dest_addr,
  input  logic [NUM_CH*LEN_W-1:0]  ch_len,
  input  logic [NUM_CH*2-1:0]      ch_mode,
  output logic [NUM_CH-1:0]        ch_busy,
  output logic [NUM_CH-1:0]        ch_done,
  output logic                     bus_request,
  input  logic                     bus_grant,
  output logic [ADDR_W-1:0]        addr_out,
  output logic [DATA_W-1:0]        data_out,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic                     mem_ready,
  output logic [CH_W-1:0]          active_ch,
  output logic [2:0]               dbg_state
`ifdef DMA_MULTI_CH_IRQ_EN
  ,
  output logic                     irq,
  input  logic [NUM_CH-1:0]        irq_clear
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARB     = 3'd1;
  localparam logic [2:0] ST_REQ_BUS = 3'd2;
  localparam logic [2:0] ST_READ    = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  localparam int BC_W = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(DATA_W / 8);

  logic [2:0]        state;
  logic [ADDR_W-1:0] src_q  [NUM_CH];
  logic [ADDR_W-1:0] dest_q [NUM_CH];
  logic [LEN_W-1:0]  cnt_q  [NUM_CH];
  logic [1:0]        mode_q [NUM_CH];
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   pick;
  logic [CH_W-1:0]   cand;
  logic [BC_W-1:0]   burst_cnt;
  logic [ADDR_W-1:0] src_next;
  logic [ADDR_W-1:0] dest_next;

  assign dbg_state = state;
  assign src_next  = mode_q[active_ch][0] ? src_q[active_ch] + STEP : src_q[active_ch];
  assign dest_next = mode_q[active_ch][1] ? dest_q[active_ch] + STEP : dest_q[active_ch];

  // Scan downwards so the busy channel closest after rr_ptr is the last (winning) assignment.
  always_comb begin
    pick = rr_ptr;
    cand = rr_ptr;
    for (int k = NUM_CH; k >= 1; k--) begin
      cand = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      if (ch_busy[cand]) pick = cand;
    end
  end

  // Handshakes: bus_request is held until a cycle with bus_grant=1; mem_read/mem_write are held
  // until a cycle with mem_ready=1, and that clock edge completes the transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ch_busy     <= '0;
      ch_done     <= '0;
      bus_request <= 1'b0;
      addr_out    <= '0;
      data_out    <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      active_ch   <= '0;
      rr_ptr      <= CH_W'(NUM_CH - 1);
      burst_cnt   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        src_q[i]  <= '0;
        dest_q[i] <= '0;
        cnt_q[i]  <= '0;
        mode_q[i] <= '0;
      end
    end else begin
      ch_done <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_start[i] && !ch_busy[i]) begin
          if (ch_len[i*LEN_W +: LEN_W] == '0) begin
            ch_done[i] <= 1'b1;
          end else begin
            src_q[i]   <= ch_src_addr[i*ADDR_W +: ADDR_W];
            dest_q[i]  <= ch_dest_addr[i*ADDR_W +: ADDR_W];
            cnt_q[i]   <= ch_len[i*LEN_W +: LEN_W];
            mode_q[i]  <= ch_mode[i*2 +: 2];
            ch_busy[i] <= 1'b1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (|ch_busy) state <= ST_ARB;
        end
        ST_ARB: begin
          active_ch   <= pick;
          rr_ptr      <= pick;
          bus_request <= 1'b1;
          burst_cnt   <= '0;
          state       <= ST_REQ_BUS;
        end
        ST_REQ_BUS: begin
          if (bus_grant) begin
            addr_out <= src_q[active_ch];
            mem_read <= 1'b1;
            state    <= ST_READ;
          end
        end
        ST_READ: begin
          if (mem_ready) begin
            data_out  <= data_in;
            addr_out  <= dest_q[active_ch];
            mem_read  <= 1'b0;
            mem_write <= 1'b1;
            state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            mem_write         <= 1'b0;
            src_q[active_ch]  <= src_next;
            dest_q[active_ch] <= dest_next;
            cnt_q[active_ch]  <= cnt_q[active_ch] - 1'b1;
            burst_cnt         <= burst_cnt + 1'b1;
            if (cnt_q[active_ch] == LEN_W'(1)) begin
              ch_done[active_ch] <= 1'b1;
              ch_busy[active_ch] <= 1'b0;
              bus_request        <= 1'b0;
              state              <= ST_RELEASE;
            end else if (burst_cnt == BC_W'(BURST_LEN - 1)) begin
              bus_request <= 1'b0;
              state       <= ST_RELEASE;
            end else begin
              addr_out <= src_next;
              mem_read <= 1'b1;
              state    <= ST_READ;
            end
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DMA_MULTI_CH_IRQ_EN
  logic [NUM_CH-1:0] irq_status;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq_status <= '0;
    else       irq_status <= (irq_status & ~irq_clear) | ch_done;
  end

  assign irq = |irq_status;
`endif

endmodule

// File: tb/tb_dma_multi_ch.sv
// Directed bench for dma_multi_ch: vector table of single-channel transfers plus
// hand-written sequences for round-robin interleave, start during a tenure, and reset mid-write.
module tb_dma_multi_ch;
  localparam int NUM_CH = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic                 clk;
  logic                 reset;
  logic [NUM_CH-1:0]    ch_start;
  logic [NUM_CH*32-1:0] ch_src_addr;
  logic [NUM_CH*32-1:0] ch_dest_addr;
  logic [NUM_CH*16-1:0] ch_len;
  logic [NUM_CH*2-1:0]  ch_mode;
  logic [NUM_CH-1:0]    ch_busy;
  logic [NUM_CH-1:0]    ch_done;
  logic                 bus_request;
  logic                 bus_grant;
  logic [31:0]          addr_out;
  logic [31:0]          data_out;
  logic [31:0]          data_in;
  logic                 mem_read;
  logic                 mem_write;
  logic                 mem_ready;
  logic [1:0]           active_ch;
  logic [2:0]           dbg_state;
`ifdef DMA_MULTI_CH_IRQ_EN
  logic                 irq;
  logic [NUM_CH-1:0]    irq_clear;
  assign irq_clear = '0;
`endif

  dma_multi_ch dut (
    .clk(clk), .reset(reset), .ch_start(ch_start), .ch_src_addr(ch_src_addr),
    .ch_dest_addr(ch_dest_addr), .ch_len(ch_len), .ch_mode(ch_mode),
    .ch_busy(ch_busy), .ch_done(ch_done), .bus_request(bus_request), .bus_grant(bus_grant),
    .addr_out(addr_out), .data_out(data_out), .data_in(data_in), .mem_read(mem_read),
    .mem_write(mem_write), .mem_ready(mem_ready), .active_ch(active_ch), .dbg_state(dbg_state)
`ifdef DMA_MULTI_CH_IRQ_EN
    , .irq(irq), .irq_clear(irq_clear)
`endif
  );

  // Memory returns a value derived from the address being read.
  assign data_in = addr_out ^ KEY;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [64:0] exp_q[$];
  logic [1:0]  tenure_q[$];
  int tests = 0;
  int fails = 0;
  int done_cnt[NUM_CH];
  int overlap_err = 0;
  int rdly = 0;
  int gdly = 0;
  int rcnt = 0;
  int gcnt = 0;
  logic prev_req = 1'b0;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus/memory responder and transfer monitor, evaluated on the falling edge.
  always @(negedge clk) begin
    logic [64:0] obs;
    logic [64:0] e;
    if (reset) begin
      mem_ready = 1'b0;
      bus_grant = 1'b0;
      rcnt = 0;
      gcnt = 0;
      prev_req = 1'b0;
    end else begin
      if (mem_read && mem_write) overlap_err++;
      if (bus_request && !prev_req) tenure_q.push_back(active_ch);
      prev_req = bus_request;
      if (!bus_request) begin
        gcnt = 0;
        bus_grant = 1'b0;
      end else begin
        bus_grant = (gcnt >= gdly);
        gcnt++;
      end
      if (!(mem_read || mem_write)) begin
        rcnt = 0;
        mem_ready = 1'b0;
      end else begin
        if (mem_ready) rcnt = 0;
        mem_ready = (rcnt >= rdly);
        rcnt++;
      end
      if (mem_ready && (mem_read || mem_write)) begin
        obs = {mem_write, addr_out, (mem_write ? data_out : data_in)};
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_xfer: got %0h expected none", obs);
        end else begin
          e = exp_q.pop_front();
          check("xfer", obs, e);
        end
      end
      for (int i = 0; i < NUM_CH; i++) if (ch_done[i]) done_cnt[i]++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_obs();
    exp_q.delete();
    tenure_q.delete();
    for (int i = 0; i < NUM_CH; i++) done_cnt[i] = 0;
    overlap_err = 0;
  endtask

  task automatic set_ch(input int ch, input logic [31:0] src, input logic [31:0] dest,
                        input logic [15:0] len, input logic [1:0] mode);
    ch_src_addr[ch*32 +: 32]  = src;
    ch_dest_addr[ch*32 +: 32] = dest;
    ch_len[ch*16 +: 16]       = len;
    ch_mode[ch*2 +: 2]        = mode;
  endtask

  task automatic push_words(input logic [31:0] src, input logic [31:0] dest,
                            input logic [1:0] mode, input int first, input int n);
    logic [31:0] a;
    logic [31:0] d;
    for (int k = first; k < first + n; k++) begin
      a = mode[0] ? src + 32'(4 * k) : src;
      d = mode[1] ? dest + 32'(4 * k) : dest;
      exp_q.push_back({1'b0, a, a ^ KEY});
      exp_q.push_back({1'b1, d, a ^ KEY});
    end
  endtask

  task automatic wait_done(input int ch, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (done_cnt[ch] >= 1) break;
      tick(1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus_request"}, bus_request, 1'b0);
    check({tag, "_mem_read"}, mem_read, 1'b0);
    check({tag, "_mem_write"}, mem_write, 1'b0);
    check({tag, "_addr_out"}, addr_out, 32'h0);
    check({tag, "_data_out"}, data_out, 32'h0);
    check({tag, "_ch_busy"}, ch_busy, 4'h0);
    check({tag, "_ch_done"}, ch_done, 4'h0);
    check({tag, "_active_ch"}, active_ch, 2'd0);
    check({tag, "_state"}, dbg_state, 3'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          ch;
    logic [31:0] src;
    logic [31:0] dest;
    logic [15:0] len;
    logic [1:0]  mode;
    int          rdly;
    int          gdly;
    int          exp_ten;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [7:0] seq;

    vecs[0] = '{0, 32'h0000_0100, 32'h0000_0200, 16'd3,  2'b11, 0, 0, 1};
    vecs[1] = '{1, 32'h0000_1000, 32'h0000_2000, 16'd10, 2'b11, 0, 0, 2};
    vecs[2] = '{3, 32'h0000_0400, 32'h0000_0300, 16'd4,  2'b01, 3, 0, 1};
    vecs[3] = '{2, 32'hFFFF_FFFC, 32'h0000_0500, 16'd2,  2'b11, 0, 0, 1};
    vecs[4] = '{1, 32'h0000_0040, 32'h0000_0080, 16'd1,  2'b00, 1, 2, 1};
    vecs[5] = '{0, 32'h0000_0010, 32'h0000_0020, 16'd0,  2'b11, 0, 0, 0};
    vecs[6] = '{3, 32'h0000_0700, 32'h0000_0800, 16'd16, 2'b10, 0, 1, 2};

    reset = 1'b1;
    ch_start = '0;
    ch_src_addr = '0;
    ch_dest_addr = '0;
    ch_len = '0;
    ch_mode = '0;
    mem_ready = 1'b0;
    bus_grant = 1'b0;
    for (int i = 0; i < NUM_CH; i++) done_cnt[i] = 0;
    tick(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    tick(2);

    for (int v = 0; v < 7; v++) begin
      clear_obs();
      rdly = vecs[v].rdly;
      gdly = vecs[v].gdly;
      push_words(vecs[v].src, vecs[v].dest, vecs[v].mode, 0, int'(vecs[v].len));
      set_ch(vecs[v].ch, vecs[v].src, vecs[v].dest, vecs[v].len, vecs[v].mode);
      ch_start[vecs[v].ch] = 1'b1;
      tick(1);
      ch_start = '0;
      check($sformatf("v%0d_start_busy", v), ch_busy[vecs[v].ch], vecs[v].len != 0);
      check($sformatf("v%0d_start_done", v), ch_done[vecs[v].ch], vecs[v].len == 0);
      wait_done(vecs[v].ch, 2000);
      tick(4);
      check($sformatf("v%0d_done_count", v), done_cnt[vecs[v].ch], 1);
      check($sformatf("v%0d_leftover", v), exp_q.size(), 0);
      check($sformatf("v%0d_tenures", v), tenure_q.size(), vecs[v].exp_ten);
      check($sformatf("v%0d_busy_end", v), ch_busy, 4'h0);
      check($sformatf("v%0d_bus_request_end", v), bus_request, 1'b0);
      check($sformatf("v%0d_rw_overlap", v), overlap_err, 0);
    end

    // Two channels started together, 10 words each: tenures must alternate ch0, ch2, ch0, ch2.
    apply_reset();
    clear_obs();
    rdly = 0;
    gdly = 0;
    push_words(32'h1000, 32'h5000, 2'b11, 0, 8);
    push_words(32'h3000, 32'h7000, 2'b11, 0, 8);
    push_words(32'h1000, 32'h5000, 2'b11, 8, 2);
    push_words(32'h3000, 32'h7000, 2'b11, 8, 2);
    set_ch(0, 32'h1000, 32'h5000, 16'd10, 2'b11);
    set_ch(2, 32'h3000, 32'h7000, 16'd10, 2'b11);
    ch_start = 4'b0101;
    tick(1);
    ch_start = '0;
    check("rr_both_busy", ch_busy, 4'b0101);
    wait_done(0, 2000);
    wait_done(2, 2000);
    tick(4);
    seq = '0;
    for (int i = 0; i < tenure_q.size() && i < 4; i++) seq[i*2 +: 2] = tenure_q[i];
    check("rr_tenure_count", tenure_q.size(), 4);
    check("rr_tenure_order", seq, 8'h88);
    check("rr_done0", done_cnt[0], 1);
    check("rr_done2", done_cnt[2], 1);
    check("rr_leftover", exp_q.size(), 0);
    check("rr_rw_overlap", overlap_err, 0);

    // Start on another channel mid-tenure, plus an ignored restart of the busy channel.
    clear_obs();
    rdly = 2;
    push_words(32'h9000, 32'hA000, 2'b11, 0, 3);
    push_words(32'hB000, 32'hC000, 2'b10, 0, 2);
    set_ch(1, 32'h9000, 32'hA000, 16'd3, 2'b11);
    ch_start[1] = 1'b1;
    tick(1);
    ch_start = '0;
    for (int c = 0; c < 100 && !mem_read; c++) tick(1);
    check("mid_reading", mem_read, 1'b1);
    set_ch(1, 32'hDEAD_0000, 32'hBEEF_0000, 16'd7, 2'b00);
    set_ch(3, 32'hB000, 32'hC000, 16'd2, 2'b10);
    ch_start = 4'b1010;
    tick(1);
    ch_start = '0;
    check("mid_busy", ch_busy, 4'b1010);
    check("mid_active", active_ch, 2'd1);
    wait_done(1, 2000);
    wait_done(3, 2000);
    tick(4);
    check("mid_done1", done_cnt[1], 1);
    check("mid_done3", done_cnt[3], 1);
    check("mid_tenures", tenure_q.size(), 2);
    check("mid_leftover", exp_q.size(), 0);

    // Reset asserted while a write strobe is pending, then a zero-length start.
    clear_obs();
    rdly = 2;
    push_words(32'h100, 32'h200, 2'b11, 0, 5);
    set_ch(0, 32'h100, 32'h200, 16'd5, 2'b11);
    ch_start[0] = 1'b1;
    tick(1);
    ch_start = '0;
    for (int c = 0; c < 100 && !mem_write; c++) tick(1);
    check("rst_in_write", mem_write, 1'b1);
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    tick(2);
    reset = 1'b0;
    clear_obs();
    tick(5);
    check("rst_no_request", tenure_q.size(), 0);
    check("rst_busy_after", ch_busy, 4'h0);
    set_ch(2, 32'h0, 32'h0, 16'd0, 2'b11);
    ch_start[2] = 1'b1;
    tick(1);
    ch_start = '0;
    check("len0_done", ch_done, 4'b0100);
    check("len0_busy", ch_busy, 4'h0);
    tick(5);
    check("len0_done_count", done_cnt[2], 1);
    check("len0_no_request", tenure_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
